// File: rtl/datapath_bird_pkg.sv
// Shared definitions for the bird datapath: control-state codes from the bird
// control FSM, VGA colour codes, sprite-painter phases and the clamped step.
package datapath_bird_pkg;

    // Control-state codes driven by the bird control FSM
    localparam logic [2:0] ST_STOP    = 3'b001;
    localparam logic [2:0] ST_START   = 3'b010;
    localparam logic [2:0] ST_FALLING = 3'b011;
    localparam logic [2:0] ST_RAISING = 3'b110;
    localparam logic [2:0] ST_DRAW    = 3'b111;

    // VGA colour codes
    localparam logic [2:0] COLOUR_BG   = 3'b000;
    localparam logic [2:0] COLOUR_BIRD = 3'b110;

    // Sprite painter phases
    typedef enum logic [1:0] {
        PH_IDLE  = 2'd0,
        PH_ERASE = 2'd1,
        PH_DRAW  = 2'd2
    } paint_phase_e;

    // One vertical step of the bird. Computed in 8 bits so neither direction
    // can wrap: rising saturates at row 0, falling saturates at max_y.
    function automatic logic [6:0] next_bird_y(
        input logic [6:0] cur_y,
        input logic       rising,
        input logic [7:0] step,
        input logic [7:0] max_y
    );
        logic [7:0] wide;
        logic [7:0] result;
        wide = {1'b0, cur_y};
        if (rising) begin
            result = (wide < step) ? 8'd0 : wide - step;
        end else begin
            result = wide + step;
            if (result > max_y) begin
                result = max_y;
            end
        end
        return result[6:0];
    endfunction

endpackage

// File: rtl/datapath_bird_sprite_painter.sv
// Erase/redraw sequencer for the bird sprite: SIZE*SIZE pixels of background
// at old_y, then SIZE*SIZE pixels of bird colour at new_y, one pixel per cycle.
module datapath_bird_sprite_painter
    import datapath_bird_pkg::*;
#(
    parameter int SIZE   = 4,
    parameter int BIRD_X = 20
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic [6:0] old_y,
    input  logic [6:0] new_y,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy
);

    localparam int LOG_SIZE = $clog2(SIZE);
    localparam int CNT_W    = 2 * LOG_SIZE;
    // SIZE is a power of two, so the last pixel index is all ones
    localparam logic [CNT_W-1:0] CNT_LAST = '1;
    localparam logic [7:0]       COL_BASE = 8'(BIRD_X);

    paint_phase_e        phase_q, phase_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [LOG_SIZE-1:0] col;
    logic [LOG_SIZE-1:0] row;

    // Column is the fast half of the pixel counter, row the slow half
    assign col = cnt_q[LOG_SIZE-1:0];
    assign row = cnt_q[CNT_W-1:LOG_SIZE];

    // Phase register and pixel counter
    always_ff @(posedge clk) begin
        if (!resetn) begin
            phase_q <= PH_IDLE;
            cnt_q   <= '0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next phase: walk the full sprite once in ERASE, once in DRAW
    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        case (phase_q)
            PH_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    phase_d = PH_ERASE;
                end
            end
            PH_ERASE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    phase_d = PH_DRAW;
                end
            end
            PH_DRAW: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    phase_d = PH_IDLE;
                end
            end
            default: begin
                phase_d = PH_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Pixel outputs decoded from the current phase; all zero while idle
    always_comb begin
        x      = '0;
        y      = '0;
        colour = COLOUR_BG;
        plot   = 1'b0;
        busy   = 1'b0;
        case (phase_q)
            PH_ERASE: begin
                x      = COL_BASE + 8'(col);
                y      = old_y + 7'(row);
                colour = COLOUR_BG;
                plot   = 1'b1;
                busy   = 1'b1;
            end
            PH_DRAW: begin
                x      = COL_BASE + 8'(col);
                y      = new_y + 7'(row);
                colour = COLOUR_BIRD;
                plot   = 1'b1;
                busy   = 1'b1;
            end
            default: begin
                x      = '0;
                y      = '0;
                colour = COLOUR_BG;
                plot   = 1'b0;
                busy   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/datapath_bird.sv
// Bird datapath: frame-tick divider, bird Y position and rise timing,
// ceiling/ground/pipe collision, and the sprite erase/redraw trigger.
module datapath_bird
    import datapath_bird_pkg::*;
#(
    parameter int SIZE        = 4,
    parameter int START_Y     = 56,
    parameter int BIRD_X      = 20,
    parameter int GROUND_Y    = 116,
    parameter int STEP        = 2,
    parameter int RISE_FRAMES = 6,
    parameter int FRAME_DIV   = 833333,
    parameter int PIPE_W      = 8,
    parameter int GAP_H       = 32
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [2:0] state,
    input  logic       press_key,
    input  logic [7:0] pipe_x,
    input  logic [6:0] pipe_gap_y,
    output logic       flag,
    output logic       touched,
    output logic       busy,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot
);

    localparam int                TICK_W     = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(FRAME_DIV - 1);
    localparam int                RISE_W     = $clog2(RISE_FRAMES + 1);
    localparam logic [RISE_W-1:0] RISE_SAT   = RISE_W'(RISE_FRAMES);
    localparam logic [6:0]        START_ROW  = 7'(START_Y);
    localparam logic [7:0]        STEP_PX    = 8'(STEP);
    localparam logic [7:0]        FLOOR_ROW  = 8'(GROUND_Y - SIZE);
    localparam logic [7:0]        GROUND_ROW = 8'(GROUND_Y);
    localparam logic [7:0]        SIZE_PX    = 8'(SIZE);
    localparam logic [7:0]        GAP_PX     = 8'(GAP_H);
    localparam logic [8:0]        BIRD_LEFT  = 9'(BIRD_X);
    localparam logic [8:0]        BIRD_RIGHT = 9'(BIRD_X + SIZE);
    localparam logic [8:0]        PIPE_PX    = 9'(PIPE_W);

    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic              move_pending_q, move_pending_d;
    logic [6:0]        bird_y_q, bird_y_d;
    logic [6:0]        old_y_q, old_y_d;
    logic [RISE_W-1:0] rise_cnt_q, rise_cnt_d;
    logic              flap_l_q, flap_l_d;
    logic              key_prev_q, key_prev_d;
    logic [2:0]        state_prev_q, state_prev_d;
    logic              start_req_q, start_req_d;
    logic              check_q, check_d;
    logic              flag_q, flag_d;
    logic              touched_q, touched_d;

    logic painter_busy;
    logic tick;
    logic in_motion;
    logic entering_start;
    logic entering_rise;
    logic draw_req;
    logic req_go;
    logic move_go;
    logic paint_start;
    logic key_edge;
    logic hit;

    logic [8:0] pipe_left;
    logic [8:0] pipe_right;
    logic [7:0] bird_top;
    logic [7:0] bird_bottom;
    logic [7:0] gap_top;
    logic [7:0] gap_bottom;
    logic       x_overlap;
    logic       in_gap;

    datapath_bird_sprite_painter #(
        .SIZE   (SIZE),
        .BIRD_X (BIRD_X)
    ) u_painter (
        .clk    (clk),
        .resetn (resetn),
        .start  (paint_start),
        .old_y  (old_y_q),
        .new_y  (bird_y_q),
        .x      (x),
        .y      (y),
        .colour (colour),
        .plot   (plot),
        .busy   (painter_busy)
    );

    assign busy    = painter_busy;
    assign flag    = flag_q;
    assign touched = touched_q;

    // Event decode: frame tick, state entries, key edge and who may start a paint.
    // A START redraw has priority; a move waits (pending kept) until the painter is free.
    always_comb begin
        tick           = (tick_cnt_q == TICK_LAST);
        in_motion      = (state == ST_RAISING) || (state == ST_FALLING);
        entering_start = (state == ST_START) && (state_prev_q != ST_START);
        entering_rise  = (state == ST_RAISING) && (state_prev_q != ST_RAISING);
        draw_req       = entering_start || start_req_q;
        req_go         = draw_req && !painter_busy;
        move_go        = in_motion && move_pending_q && !painter_busy && !draw_req;
        paint_start    = req_go || move_go;
        key_edge       = press_key && !key_prev_q;
    end

    // Collision test on the current bird position against ceiling, ground and pipe
    always_comb begin
        pipe_left   = {1'b0, pipe_x};
        pipe_right  = pipe_left + PIPE_PX;
        bird_top    = {1'b0, bird_y_q};
        bird_bottom = bird_top + SIZE_PX;
        gap_top     = {1'b0, pipe_gap_y};
        gap_bottom  = gap_top + GAP_PX;
        x_overlap   = (BIRD_LEFT < pipe_right) && (pipe_left < BIRD_RIGHT);
        in_gap      = (bird_top >= gap_top) && (bird_bottom <= gap_bottom);
        hit         = (bird_y_q == 7'd0) || (bird_bottom >= GROUND_ROW) || (x_overlap && !in_gap);
    end

    // Next-state for the tick divider, position, rise counter, flap latch and flags
    always_comb begin
        // NOTE: every _d takes its held value first, so no branch can leave one unassigned and infer a latch.
        tick_cnt_d     = tick ? '0 : tick_cnt_q + 1'b1;
        move_pending_d = move_pending_q;
        bird_y_d       = bird_y_q;
        old_y_d        = old_y_q;
        rise_cnt_d     = rise_cnt_q;
        flap_l_d       = flap_l_q;
        key_prev_d     = press_key;
        state_prev_d   = state;
        start_req_d    = draw_req && !req_go;
        check_d        = move_go;
        flag_d         = 1'b0;
        touched_d      = touched_q;

        // A tick in the same cycle as a move re-arms the pending move
        if (move_go) begin
            move_pending_d = 1'b0;
        end
        if (tick) begin
            move_pending_d = 1'b1;
        end
        if (state == ST_STOP) begin
            move_pending_d = 1'b0;
        end

        if (entering_rise) begin
            rise_cnt_d = '0;
        end

        if (state == ST_FALLING) begin
            if (key_edge) begin
                flap_l_d = 1'b1;
            end
        end else begin
            flap_l_d = 1'b0;
        end

        if (state == ST_START) begin
            bird_y_d   = START_ROW;
            rise_cnt_d = '0;
            if (entering_start) begin
                old_y_d = bird_y_q;
            end
        end

        if (move_go) begin
            old_y_d  = bird_y_q;
            bird_y_d = next_bird_y(bird_y_q, state == ST_RAISING, STEP_PX, FLOOR_ROW);
            if ((state == ST_RAISING) && (rise_cnt_d != RISE_SAT)) begin
                rise_cnt_d = rise_cnt_d + 1'b1;
            end
        end

        case (state)
            ST_RAISING:                  flag_d = (rise_cnt_q >= RISE_SAT);
            ST_FALLING:                  flag_d = flap_l_q;
            ST_START, ST_STOP, ST_DRAW:  flag_d = 1'b0;
            default:                     flag_d = 1'b0;
        endcase

        if (state == ST_START) begin
            touched_d = 1'b0;
        end else if (check_q && hit) begin
            touched_d = 1'b1;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values and updates together.
        if (!resetn) begin
            tick_cnt_q     <= '0;
            move_pending_q <= 1'b0;
            bird_y_q       <= START_ROW;
            old_y_q        <= START_ROW;
            rise_cnt_q     <= '0;
            flap_l_q       <= 1'b0;
            key_prev_q     <= 1'b0;
            state_prev_q   <= 3'b000;
            start_req_q    <= 1'b0;
            check_q        <= 1'b0;
            flag_q         <= 1'b0;
            touched_q      <= 1'b0;
        end else begin
            tick_cnt_q     <= tick_cnt_d;
            move_pending_q <= move_pending_d;
            bird_y_q       <= bird_y_d;
            old_y_q        <= old_y_d;
            rise_cnt_q     <= rise_cnt_d;
            flap_l_q       <= flap_l_d;
            key_prev_q     <= key_prev_d;
            state_prev_q   <= state_prev_d;
            start_req_q    <= start_req_d;
            check_q        <= check_d;
            flag_q         <= flag_d;
            touched_q      <= touched_d;
        end
    end

endmodule

// File: tb/tb_datapath_bird.sv
// Directed bench for datapath_bird with a 4-cycle frame tick.
module tb_datapath_bird;

    localparam int PIX = 16;   // SIZE*SIZE pixels per phase

    logic       clk = 1'b0;
    logic       resetn;
    logic [2:0] state;
    logic       press_key;
    logic [7:0] pipe_x;
    logic [6:0] pipe_gap_y;
    logic       flag;
    logic       touched;
    logic       busy;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;

    int n_checks = 0;
    int n_err    = 0;

    // Results of the most recent captured erase/redraw
    logic [6:0] c_ey, c_dy, c_ly;
    logic [7:0] c_ex, c_lx;
    logic [2:0] c_ec, c_dc;
    int         c_nplot;
    logic       c_idle;

    datapath_bird #(.FRAME_DIV(4)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .state      (state),
        .press_key  (press_key),
        .pipe_x     (pipe_x),
        .pipe_gap_y (pipe_gap_y),
        .flag       (flag),
        .touched    (touched),
        .busy       (busy),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait for the next paint to begin (skipping any one already in progress),
    // then record key pixels over its 2*PIX cycles and the cycle after it.
    task automatic capture();
        int w;
        w = 0;
        while (plot !== 1'b0 && w < 200) begin step(); w++; end
        while (plot !== 1'b1 && w < 400) begin step(); w++; end
        if (plot !== 1'b1) begin
            check("capture_timeout", 32'd1, 32'd0);
        end
        c_nplot = 0;
        for (int i = 0; i < 2 * PIX; i++) begin
            if (i == 0) begin c_ey = y; c_ex = x; c_ec = colour; end
            if (i == PIX) begin c_dy = y; c_dc = colour; end
            if (i == 2 * PIX - 1) begin c_ly = y; c_lx = x; end
            if (plot === 1'b1) c_nplot++;
            step();
        end
        c_idle = (plot === 1'b0);
    endtask

    initial begin
        int exp_y;
        int guard;
        int n;

        resetn     = 1'b0;
        state      = 3'b010;
        press_key  = 1'b0;
        pipe_x     = 8'd200;
        pipe_gap_y = 7'd0;
        step(); step(); step();

        // Reset values
        check("rst_plot", plot, 0);
        check("rst_busy", busy, 0);
        check("rst_flag", flag, 0);
        check("rst_touched", touched, 0);
        check("rst_x", x, 0);
        check("rst_y", y, 0);
        check("rst_colour", colour, 0);

        // First START cycle: one erase/redraw at row 56
        resetn = 1'b1;
        capture();
        check("start_nplot", c_nplot, 32);
        check("start_idle_after", c_idle, 1);
        check("start_erase_row", c_ey, 56);
        check("start_erase_x", c_ex, 20);
        check("start_erase_colour", c_ec, 0);
        check("start_draw_row", c_dy, 56);
        check("start_draw_colour", c_dc, 6);
        check("start_last_row", c_ly, 59);
        check("start_last_x", c_lx, 23);

        // RAISING: 2 rows up per move, apex flag after the 6th move
        state = 3'b110;
        for (int k = 1; k <= 7; k++) begin
            capture();
            check($sformatf("rise%0d_erase_row", k), c_ey, 56 - 2 * (k - 1));
            check($sformatf("rise%0d_draw_row", k), c_dy, 56 - 2 * k);
            check($sformatf("rise%0d_colours", k), {c_ec, c_dc}, {3'd0, 3'd6});
            if (k == 5) check("rise5_flag", flag, 0);
            if (k >= 6) check($sformatf("rise%0d_flag", k), flag, 1);
        end

        // FALLING: flap latch from a key edge; the move to 44 is painting meanwhile
        state = 3'b011;
        step(); step();
        check("fall_enter_flag", flag, 0);
        press_key = 1'b1;
        step(); step();
        check("flap_flag", flag, 1);
        for (int i = 0; i < 10; i++) step();
        check("flap_held_flag", flag, 1);
        state = 3'b111;
        step(); step();
        check("leave_fall_flag", flag, 0);
        state = 3'b011;
        for (int i = 0; i < 5; i++) step();
        check("no_second_edge_flag", flag, 0);
        press_key = 1'b0;

        // Keep falling to the ground clamp at 112
        exp_y = 44;
        guard = 0;
        while (exp_y < 112 && guard < 60) begin
            exp_y = (exp_y + 2 > 112) ? 112 : exp_y + 2;
            capture();
            check($sformatf("fall_row_%0d", exp_y), c_dy, exp_y);
            if (exp_y == 110) check("touched_before_ground", touched, 0);
            guard++;
        end
        check("ground_touched", touched, 1);
        capture();
        check("clamp_erase_row", c_ey, 112);
        check("clamp_draw_row", c_dy, 112);

        // STOP: no moves, collision held
        state = 3'b001;
        for (int i = 0; i < 40; i++) step();
        n = 0;
        for (int i = 0; i < 60; i++) begin
            if (plot === 1'b1) n++;
            step();
        end
        check("stop_no_plot", n, 0);
        check("stop_busy", busy, 0);
        check("stop_touched_held", touched, 1);

        // START: back to 56, collision cleared
        state = 3'b010;
        capture();
        check("restart_erase_row", c_ey, 112);
        check("restart_draw_row", c_dy, 56);
        check("restart_touched", touched, 0);

        // Pipe overlapping the bird column, gap 70..101 misses rows 56..59
        pipe_x     = 8'd100;
        pipe_gap_y = 7'd0;
        state      = 3'b011;
        capture();
        check("pipeA_fall_row", c_dy, 58);
        check("pipeA_far_touched", touched, 0);
        pipe_x     = 8'd18;
        pipe_gap_y = 7'd70;
        state      = 3'b110;
        capture();
        state = 3'b111;
        check("pipeA_rise_row", c_dy, 56);
        check("pipeA_touched", touched, 1);

        // Same geometry with gap 50..81 enclosing the bird
        state = 3'b010;
        capture();
        check("pipeB_start_touched", touched, 0);
        pipe_x = 8'd100;
        state  = 3'b011;
        capture();
        pipe_x     = 8'd18;
        pipe_gap_y = 7'd50;
        state      = 3'b110;
        capture();
        state = 3'b111;
        check("pipeB_rise_row", c_dy, 56);
        check("pipeB_touched", touched, 0);

        // Deferred tick: next move starts exactly one idle cycle after busy drops
        state = 3'b011;
        guard = 0;
        while (busy !== 1'b1 && guard < 10) begin step(); guard++; end
        n = 0;
        while (busy === 1'b1 && n < 100) begin step(); n++; end
        check("busy_len", n, 32);
        n = 0;
        while (busy !== 1'b1 && n < 10) begin step(); n++; end
        check("idle_gap", n, 1);

        // Reset mid-draw aborts the paint
        for (int i = 0; i < 5; i++) step();
        check("mid_draw_plot", plot, 1);
        resetn = 1'b0;
        step();
        check("abort_plot", plot, 0);
        check("abort_busy", busy, 0);
        resetn = 1'b1;
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
